// File: rtl/seq_alu.sv
// seq_alu: handshaked, parametrised ALU with registered result and condition
// codes. Single-cycle ops complete one cycle after acceptance; MUL runs an
// iterative shift-add loop of WIDTH cycles before presenting its result.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic             n,
    output logic             z,
    output logic             p,
    output logic             c,
    output logic             v,
    output logic             illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_CMP = 4'h4,
        OP_XOR = 4'h5,
        OP_NOT = 4'h6,
        OP_SHL = 4'h7,
        OP_SHR = 4'h8,
        OP_SRA = 4'h9,
        OP_MUL = 4'hA
    } op_t;

    localparam logic [SHW:0] MUL_CYCLES = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CNT_LAST   = (SHW + 1)'(1);

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SHW:0]     cnt;

    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [WIDTH:0]   sra_w;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_wr;
    logic             alu_ill;

    assign sh = b[SHW-1:0];

    // Single-cycle datapath: result, carry and overflow for every non-MUL opcode.
    // Shifts run at WIDTH+1 bits so the extra bit captures the last bit shifted
    // out; a shift by zero leaves that bit clear.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shl_w   = {1'b0, a} << sh;
        shr_w   = {a, 1'b0} >> sh;
        sra_w   = $unsigned($signed({a, 1'b0}) >>> sh);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b1;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                alu_wr  = (op == OP_SUB);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
            end
            OP_SRA: begin
                alu_res = sra_w[WIDTH:1];
                alu_c   = sra_w[0];
            end
            OP_MUL: alu_res = '0;
            default: begin
                alu_wr  = 1'b0;
                alu_ill = 1'b1;
            end
        endcase
    end

    // One shift-add multiply step: accumulate the multiplicand when the
    // current multiplier bit is set.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // Control FSM with registered handshake, result and condition-code outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            wr_en     <= 1'b0;
            n         <= 1'b0;
            z         <= 1'b1;
            p         <= 1'b0;
            c         <= 1'b0;
            v         <= 1'b0;
            illegal   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (op == OP_MUL) begin
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= MUL_CYCLES;
                            state  <= S_MUL;
                        end else begin
                            result    <= alu_res;
                            wr_en     <= alu_wr;
                            n         <= alu_res[WIDTH-1];
                            z         <= (alu_res == '0);
                            p         <= ~alu_res[WIDTH-1] & (|alu_res);
                            c         <= alu_c;
                            v         <= alu_v;
                            illegal   <= alu_ill;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        result    <= acc_next;
                        wr_en     <= 1'b1;
                        n         <= acc_next[WIDTH-1];
                        z         <= (acc_next == '0);
                        p         <= ~acc_next[WIDTH-1] & (|acc_next);
                        c         <= 1'b0;
                        v         <= 1'b0;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors for seq_alu with a queue-based scoreboard.
// The driver pushes the expected {result, wr_en, n, z, p, c, v, illegal}
// word for each request; a monitor pops and compares on every output handshake.
module tb_seq_alu;

    localparam int W = 16;

    typedef logic [W+6:0] exp_t;
    typedef struct {
        string name;
        exp_t  word;
    } sb_entry_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         wr_en;
    logic         fn, fz, fp, fc, fv;
    logic         illegal;

    sb_entry_t sb[$];
    int        errors = 0;
    int        checks = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .wr_en     (wr_en),
        .n         (fn),
        .z         (fz),
        .p         (fp),
        .c         (fc),
        .v         (fv),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input logic [W-1:0] res, input logic wr, input logic en,
                                input logic ez, input logic ep, input logic ec,
                                input logic ev, input logic ei);
        return {res, wr, en, ez, ep, ec, ev, ei};
    endfunction

    function automatic exp_t observed();
        return {result, wr_en, fn, fz, fp, fc, fv, illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare every presented-and-accepted result against the scoreboard.
    initial begin : monitor
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", observed());
                end else begin
                    e = sb.pop_front();
                    chk(e.name, 32'(observed()), 32'(e.word));
                end
            end
        end
    end

    // Wait for in_ready, present one request and hold it across the accepting edge.
    task automatic accept(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int guard = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, expected 1", in_ready);
        end
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        op       = 4'($urandom);
    endtask

    task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input exp_t w, input int exp_lat);
        int   lat;
        logic ready_seen;
        sb.push_back('{name, w});
        accept(o, x, y);
        lat        = 1;
        ready_seen = 1'b0;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) ready_seen = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (in_ready !== 1'b0) ready_seen = 1'b1;
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_in_ready_low"}, 32'(ready_seen), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_state", 32'(observed()), 32'(ex(16'h0000, 0, 0, 1, 0, 0, 0, 0)));

        //    name          op     a         b         result    wr n z p c v ill  latency
        issue("add_ovf",    4'h0, 16'h7FFF, 16'h0001, ex(16'h8000, 1, 1, 0, 0, 0, 1, 0), 1);
        issue("sub_neg",    4'h1, 16'h0003, 16'h0007, ex(16'hFFFC, 1, 1, 0, 0, 0, 0, 0), 1);
        issue("cmp_eq",     4'h4, 16'h0007, 16'h0007, ex(16'h0000, 0, 0, 1, 0, 1, 0, 0), 1);
        issue("mul_small",  4'hA, 16'h0123, 16'h0011, ex(16'h1353, 1, 0, 0, 1, 0, 0, 0), 17);
        issue("mul_ffff",   4'hA, 16'hFFFF, 16'hFFFF, ex(16'h0001, 1, 0, 0, 1, 0, 0, 0), 17);
        issue("shl_1",      4'h7, 16'h8001, 16'h0001, ex(16'h0002, 1, 0, 0, 1, 1, 0, 0), 1);
        issue("sra_15",     4'h9, 16'h8000, 16'h000F, ex(16'hFFFF, 1, 1, 0, 0, 0, 0, 0), 1);
        issue("shr_15",     4'h8, 16'h8000, 16'h000F, ex(16'h0001, 1, 0, 0, 1, 0, 0, 0), 1);
        issue("shl_0",      4'h7, 16'h1234, 16'h0010, ex(16'h1234, 1, 0, 0, 1, 0, 0, 0), 1);
        issue("shr_1",      4'h8, 16'h0003, 16'h0001, ex(16'h0001, 1, 0, 0, 1, 1, 0, 0), 1);
        issue("and",        4'h2, 16'hF0F0, 16'h3C3C, ex(16'h3030, 1, 0, 0, 1, 0, 0, 0), 1);
        issue("or",         4'h3, 16'hF0F0, 16'h0F0F, ex(16'hFFFF, 1, 1, 0, 0, 0, 0, 0), 1);
        issue("xor",        4'h5, 16'hAAAA, 16'hAAAA, ex(16'h0000, 1, 0, 1, 0, 0, 0, 0), 1);
        issue("not",        4'h6, 16'h00FF, 16'h1234, ex(16'hFF00, 1, 1, 0, 0, 0, 0, 0), 1);
        issue("add_carry",  4'h0, 16'hFFFF, 16'h0001, ex(16'h0000, 1, 0, 1, 0, 1, 0, 0), 1);
        issue("sub_ovf",    4'h1, 16'h8000, 16'h0001, ex(16'h7FFF, 1, 0, 0, 1, 1, 1, 0), 1);

        // Backpressure: result must hold and new requests must be ignored.
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue("bp_add", 4'h0, 16'd10, 16'd5, ex(16'h000F, 1, 0, 0, 1, 0, 0, 0), 1);
        in_valid = 1'b1;
        op       = 4'h1;
        a        = 16'd1;
        b        = 16'd2;
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold", {12'd0, out_valid, in_ready, fp, result}, {12'd0, 1'b1, 1'b0, 1'b1, 16'h000F});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        issue("bp_next", 4'h0, 16'd1, 16'd1, ex(16'h0002, 1, 0, 0, 1, 0, 0, 0), 1);

        // Reset during a multiply aborts it.
        accept(4'hA, 16'h0123, 16'h0011);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mul_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mul_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mul_state", 32'(observed()), 32'(ex(16'h0000, 0, 0, 1, 0, 0, 0, 0)));
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("rst_mul_no_output", 32'(seen), 32'd0);
        chk("rst_mul_sb_empty", 32'(sb.size()), 32'd0);

        issue("ill_1111",   4'hF, 16'h0005, 16'h0006, ex(16'h0000, 0, 0, 1, 0, 0, 0, 1), 1);
        issue("ill_1011",   4'hB, 16'h8000, 16'h8000, ex(16'h0000, 0, 0, 1, 0, 0, 0, 1), 1);
        issue("add_clears", 4'h0, 16'd2, 16'd3, ex(16'h0005, 1, 0, 0, 1, 0, 0, 0), 1);

        @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
